shift_unit_seq: RTL and testbench
=================================

# shift_unit_seq

Parametrised, iterative multi-bit shifter/rotator for the multi-cycle datapath. It accepts a WIDTH-bit operand, a 3-bit operation code and a shift amount. It performs one single-bit step per clock and returns the result with a carry flag (the last bit shifted out) under a start/busy/done handshake. The op encoding is unchanged from the existing single-bit shift unit, so the control unit decodes both identically.

## Interface
- WIDTH, 8, operand/result width; power of two, ≥ 4.
- AMT_W, $clog2(WIDTH), shift-amount width; amt range 0..WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- in  input  WIDTH  operand; captured with start.
- op  input  3  operation; captured with start.
- amt  input  AMT_W  number of single-bit steps; captured with start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; out/carry valid from this cycle.
- out  output  WIDTH  result; holds until the next completion.
- carry  output  1  last bit shifted or rotated out; 0 if no bit left the operand.

## Operation
- Op encoding (one step):
  - 000: RTL, {w[W-2:0], w[W-1]}, c=w[W-1].
  - 100: RTR, {w[0], w[W-1:1]}, c=w[0].
  - 010 and 011: SHL, w<<1, c=w[W-1].
  - 110: ASR, {w[W-1], w[W-1:1]}, c=w[0].
  - 111: LSR, {1'b0, w[W-1:1]}, c=w[0].
  - 001 and 101: pass, w unchanged, c=0.
- Internal state: work register w (WIDTH), step counter cnt (AMT_W), latched op, running carry c.
- FSM states:
  - IDLE: busy=0. If start=1, load w=in, op, cnt=amt, c=0; go to SHIFT.
  - SHIFT: busy=1.
    - If cnt≠0: apply one step to w and c, cnt−1.
    - If cnt=0: out<=w, carry<=c, done<=1, go to IDLE.
- amt=0 returns in unchanged with carry=0 for every op, including rotates.
- Pass ops still consume amt+1 cycles, so latency is uniform across ops.
- start while busy=1 is ignored. No queueing, no error flag.
- Inputs are only sampled at the capture edge. Changing in/op/amt afterwards has no effect.
- Reset (async, any state, including mid-operation) clears outputs and state:
  - out=0, carry=0, done=0, busy=0.
  - w=0, cnt=0, c=0, state=IDLE.
  - Any operation in flight is discarded. No done is produced for it.

## Timing
- Edge E0: start=1 with busy=0 is captured; busy rises after E0.
- Edges E1..E(amt): one step per edge.
- Edge E(amt+1): out and carry update, done=1, busy=0.
- Latency: done is visible amt+1 cycles after the capture edge. Throughput: one operation per amt+1 cycles.
- done is high for exactly one cycle. out and carry stay stable until the next completion.
- Back-to-back: start=1 during the done cycle is accepted (busy=0 then). No idle gap is required.
- busy and done are never both 1.

## Test plan
- Reset: assert rst_n=0 mid-operation (RTL, amt=3, after 2 cycles).
  - Immediately out=0x00, carry=0, busy=0, done=0.
  - After release, no done pulse until a new start.
- Rotates, WIDTH=8:
  - RTL in=0x81 amt=1 -> out=0x03, carry=1, done 2 cycles after capture.
  - RTR in=0x01 amt=7 -> out=0x02, carry=0, done 8 cycles after capture.
- Shifts:
  - SHL (op 011) in=0xC3 amt=2 -> out=0x0C, carry=1.
  - ASR in=0x90 amt=3 -> out=0xF2, carry=0.
  - LSR in=0x90 amt=5 -> out=0x04, carry=1, 6-cycle latency.
- Edge cases:
  - amt=0 with RTL in=0xA5 -> out=0xA5, carry=0, done 1 cycle after capture.
  - Pass (op 101) in=0x3C amt=4 -> out=0x3C, carry=0, done after 5 cycles.
- Handshake:
  - A second start with different operands, issued while busy, is ignored; the first result is returned unchanged.
  - A start during the done cycle is accepted and completes with correct latency.
  - Over a long random run, busy and done are never both high.

Source files
------------

// File: rtl/shift_unit_seq.sv
// Iterative shifter/rotator: one single-bit step per clock under a start/busy/done handshake.
// Result and carry are registered on completion and held until the next one.
module shift_unit_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carry
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   step_res;

  // One step of the selected operation; returns {carry_out, new_word}.
  function automatic logic [WIDTH:0] step_once(input logic [WIDTH-1:0] w, input logic [2:0] o);
    logic [WIDTH:0] r;
    case (o)
      3'b000:         r = {w[WIDTH-1], w[WIDTH-2:0], w[WIDTH-1]};
      3'b100:         r = {w[0], w[0], w[WIDTH-1:1]};
      3'b010, 3'b011: r = {w[WIDTH-1], w[WIDTH-2:0], 1'b0};
      3'b110:         r = {w[0], w[WIDTH-1], w[WIDTH-1:1]};
      3'b111:         r = {w[0], 1'b0, w[WIDTH-1:1]};
      default:        r = {1'b0, w};
    endcase
    return r;
  endfunction

  assign step_res = step_once(w_q, op_q);

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    c_d     = c_q;
    out_d   = out_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          w_d     = in;
          op_d    = op;
          cnt_d   = amt;
          c_d     = 1'b0;
          state_d = SHIFT;
        end
      end
      default: begin
        if (cnt_q != '0) begin
          w_d   = step_res[WIDTH-1:0];
          c_d   = step_res[WIDTH];
          cnt_d = cnt_q - AMT_W'(1);
        end else begin
          out_d   = w_q;
          carry_d = c_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      c_q     <= 1'b0;
      out_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      c_q     <= c_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q == SHIFT);
  assign done  = done_q;
  assign out   = out_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed and randomised bench for shift_unit_seq at WIDTH=8.
module tb_shift_unit_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in_i = '0;
  logic [2:0] op_i = '0;
  logic [2:0] amt_i = '0;
  logic       busy, done, carry;
  logic [7:0] out;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  shift_unit_seq #(.WIDTH(8), .AMT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in(in_i), .op(op_i), .amt(amt_i),
    .busy(busy), .done(done), .out(out), .carry(carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic [2:0] op;
    logic [2:0] amt;
    logic [7:0] exp_out;
    logic       exp_c;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (busy && done) begin
        errors++;
        $display("FAIL busy_and_done: got busy=%0b done=%0b expected not both 1", busy, done);
      end
    end
  end

  // Wait for done, returning cycles counted from the capture edge; called at the negedge after capture.
  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) break;
    end
  endtask

  task automatic do_op(input string nm, input logic [7:0] d, input logic [2:0] o,
                       input logic [2:0] a, input logic [7:0] eo, input logic ec);
    int lat;
    @(negedge clk);
    start = 1'b1; in_i = d; op_i = o; amt_i = a;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; in_i = ~d; op_i = ~o; amt_i = ~a;
    check({nm, " busy"}, 32'(busy), 32'd1);
    wait_done(lat);
    check({nm, " latency"}, 32'(lat), 32'(a) + 32'd1);
    check({nm, " out"}, 32'(out), 32'(eo));
    check({nm, " carry"}, 32'(carry), 32'(ec));
  endtask

  // Reference computed directly from the whole shift amount, not step by step.
  task automatic model(input logic [7:0] d, input logic [2:0] o, input logic [2:0] a,
                       output logic [7:0] r, output logic c);
    logic signed [7:0] s;
    int n;
    n = int'(a);
    s = d;
    r = d;
    c = 1'b0;
    if (n != 0) begin
      case (o)
        3'b000: begin r = (d << n) | (d >> (8 - n)); c = r[0]; end
        3'b100: begin r = (d >> n) | (d << (8 - n)); c = r[7]; end
        3'b010, 3'b011: begin r = d << n; c = d[8 - n]; end
        3'b110: begin r = s >>> n; c = d[n - 1]; end
        3'b111: begin r = d >> n; c = d[n - 1]; end
        default: begin r = d; c = 1'b0; end
      endcase
    end
  endtask

  vec_t vecs[10];

  initial begin
    int lat;
    logic [7:0] rd, ro;
    logic [2:0] rop, ra;
    logic rc;

    vecs[0] = '{8'h81, 3'b000, 3'd1, 8'h03, 1'b1};
    vecs[1] = '{8'h01, 3'b100, 3'd7, 8'h02, 1'b0};
    vecs[2] = '{8'hC3, 3'b011, 3'd2, 8'h0C, 1'b1};
    vecs[3] = '{8'h90, 3'b110, 3'd3, 8'hF2, 1'b0};
    vecs[4] = '{8'h90, 3'b111, 3'd5, 8'h04, 1'b1};
    vecs[5] = '{8'hA5, 3'b000, 3'd0, 8'hA5, 1'b0};
    vecs[6] = '{8'h3C, 3'b101, 3'd4, 8'h3C, 1'b0};
    vecs[7] = '{8'h81, 3'b010, 3'd1, 8'h02, 1'b1};
    vecs[8] = '{8'h5A, 3'b100, 3'd0, 8'h5A, 1'b0};
    vecs[9] = '{8'h3C, 3'b001, 3'd3, 8'h3C, 1'b0};

    repeat (2) @(negedge clk);
    check("reset out", 32'(out), 32'h00);
    check("reset carry", 32'(carry), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++)
      do_op($sformatf("vec%0d", i), vecs[i].din, vecs[i].op, vecs[i].amt, vecs[i].exp_out, vecs[i].exp_c);

    // Start held high with different operands while busy must be ignored.
    @(negedge clk);
    start = 1'b1; in_i = 8'h90; op_i = 3'b111; amt_i = 3'd5;
    @(posedge clk);
    @(negedge clk);
    in_i = 8'hFF; op_i = 3'b000; amt_i = 3'd1;
    wait_done(lat);
    check("busy_start latency", 32'(lat), 32'd6);
    check("busy_start out", 32'(out), 32'h04);
    check("busy_start carry", 32'(carry), 32'd1);

    // Start issued in the done cycle is accepted.
    in_i = 8'h90; op_i = 3'b110; amt_i = 3'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; in_i = 8'h00;
    check("b2b busy", 32'(busy), 32'd1);
    wait_done(lat);
    check("b2b latency", 32'(lat), 32'd4);
    check("b2b out", 32'(out), 32'hF2);
    check("b2b carry", 32'(carry), 32'd0);

    // Reset in the middle of an RTL amt=3 operation.
    @(negedge clk);
    start = 1'b1; in_i = 8'h81; op_i = 3'b000; amt_i = 3'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst out", 32'(out), 32'h00);
    check("midrst carry", 32'(carry), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    lat = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) lat++;
    end
    check("post_rst quiet", 32'(lat), 32'd0);

    for (int k = 0; k < 300; k++) begin
      rd = 8'($urandom);
      rop = 3'($urandom);
      ra = 3'($urandom);
      model(rd, rop, ra, ro, rc);
      do_op($sformatf("rand%0d op%0b amt%0d in%02h", k, rop, ra, rd), rd, rop, ra, ro, rc);
    end

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
